// File: rtl/sound_sched.sv
// Note scheduler: plays background music and overrides it with short, fixed
// sound effects (win/lose/tie), followed by a one-tick silent gap.
module sound_sched #(
  parameter int NOTE_W     = 5,
  parameter int STEP_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              bgm_en,
  input  logic [NOTE_W-1:0] bgm_note,
  input  logic [2:0]        sfx_req,
  output logic [NOTE_W-1:0] note,
  output logic              bgm_adv,
  output logic              sfx_busy,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BGM  = 2'd1,
    SFX  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [1:0] FX_WIN  = 2'd0;
  localparam logic [1:0] FX_LOSE = 2'd1;
  localparam logic [1:0] FX_TIE  = 2'd2;

  localparam int HOLD_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STEP_TICKS - 1);

  state_t            state, state_n;
  logic [NOTE_W-1:0] note_n;
  logic              adv_n, busy_n;
  logic [2:0]        pend, pend_n, eff, sel_mask;
  logic [1:0]        fx, fx_n, sel_fx, step, step_n;
  logic [HOLD_W-1:0] hold, hold_n;

  function automatic logic [NOTE_W-1:0] fx_note(input logic [1:0] f, input logic [1:0] s);
    logic [4:0] n;
    n = 5'd0;
    case (f)
      FX_WIN:  case (s) 2'd0: n = 5'd8;  2'd1: n = 5'd10; 2'd2: n = 5'd12; default: n = 5'd15; endcase
      FX_LOSE: case (s) 2'd0: n = 5'd12; 2'd1: n = 5'd10; 2'd2: n = 5'd8;  default: n = 5'd1;  endcase
      FX_TIE:  case (s) 2'd0: n = 5'd8;  2'd1: n = 5'd0;  2'd2: n = 5'd8;  default: n = 5'd0;  endcase
      default: n = 5'd0;
    endcase
    return NOTE_W'(n);
  endfunction

  // A request landing on the tick cycle itself is served on that tick.
  assign eff = pend | sfx_req;

  always_comb begin
    sel_fx   = FX_WIN;
    sel_mask = 3'b000;
    if (eff[2]) begin
      sel_fx   = FX_WIN;
      sel_mask = 3'b100;
    end else if (eff[1]) begin
      sel_fx   = FX_LOSE;
      sel_mask = 3'b010;
    end else if (eff[0]) begin
      sel_fx   = FX_TIE;
      sel_mask = 3'b001;
    end
  end

  always_comb begin
    state_n = state;
    note_n  = note;
    adv_n   = 1'b0;
    fx_n    = fx;
    step_n  = step;
    hold_n  = hold;
    pend_n  = eff;
    if (tick) begin
      case (state)
        SFX: begin
          // Effects are never preempted; new requests just accumulate in pend.
          if (hold == HOLD_LAST) begin
            hold_n = '0;
            if (step == 2'd3) begin
              state_n = GAP;
              note_n  = '0;
            end else begin
              step_n = step + 2'd1;
              note_n = fx_note(fx, step + 2'd1);
            end
          end else begin
            hold_n = hold + HOLD_W'(1);
          end
        end
        default: begin
          if (eff != 3'b000) begin
            state_n = SFX;
            fx_n    = sel_fx;
            step_n  = 2'd0;
            hold_n  = '0;
            note_n  = fx_note(sel_fx, 2'd0);
            pend_n  = eff & ~sel_mask;
          end else if (bgm_en) begin
            state_n = BGM;
            // Only a tick spent in BGM consumes a score note; entering BGM is silent.
            if (state == BGM) begin
              note_n = bgm_note;
              adv_n  = 1'b1;
            end else begin
              note_n = '0;
            end
          end else begin
            state_n = IDLE;
            note_n  = '0;
          end
        end
      endcase
    end
  end

  assign busy_n = (state_n == SFX) || (state_n == GAP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      note     <= '0;
      bgm_adv  <= 1'b0;
      sfx_busy <= 1'b0;
      pend     <= 3'b000;
      fx       <= FX_WIN;
      step     <= 2'd0;
      hold     <= '0;
    end else begin
      state    <= state_n;
      note     <= note_n;
      bgm_adv  <= adv_n;
      sfx_busy <= busy_n;
      pend     <= pend_n;
      fx       <= fx_n;
      step     <= step_n;
      hold     <= hold_n;
    end
  end

  assign state_o = state;

endmodule

// File: doc/sound_sched.md
SOUND_SCHED -- requirements
Module: sound_sched

Interface
REQ-001 Parameter NOTE_W, default 5: width of the note index (0 = mute, 1..21 = tone table index).
REQ-002 Parameter STEP_TICKS, default 2: number of ticks each sound-effect note is held.
REQ-003 Port clk, input, 1: system clock (50 MHz).
REQ-004 Port rst, input, 1: reset; asynchronous, active-low.
REQ-005 Port tick, input, 1: single-cycle note-rate strobe (4 Hz); all sequencing advances only on cycles with tick=1.
REQ-006 Port bgm_en, input, 1: background music enable.
REQ-007 Port bgm_note, input, NOTE_W: current background-score note, supplied by the score ROM.
REQ-008 Port sfx_req, input, 3: sound-effect request pulses; [2]=win, [1]=lose, [0]=tie.
REQ-009 Port note, output, NOTE_W: registered note index driven to the tone generator.
REQ-010 Port bgm_adv, output, 1: one-cycle pulse that advances the score pointer.
REQ-011 Port sfx_busy, output, 1: high while a sound effect or its trailing gap is playing.
REQ-012 Port state_o, output, 2: current state code (IDLE=0, BGM=1, SFX=2, GAP=3).

Function
REQ-013 The block SHALL implement the states IDLE, BGM, SFX and GAP, and SHALL change state only on tick cycles.
REQ-014 The block SHALL capture sfx requests as pend <= pend | sfx_req on every cycle.
REQ-015 The value eff = pend | sfx_req SHALL be evaluated on a tick cycle, so a request arriving on that same tick cycle is served at that tick.
REQ-016 Selection SHALL use fixed priority win > lose > tie. Only the selected bit SHALL be cleared from pend; other pending bits stay.
REQ-017 From IDLE or BGM, on tick with eff != 0: go to SFX, load the selected effect, reset the step index and hold counter, and drive note to step 0 of the effect.
REQ-018 Effect note sequences, 4 steps each: win = 8,10,12,15; lose = 12,10,8,1; tie = 8,0,8,0.
REQ-019 In SFX, the hold counter SHALL count ticks 0..STEP_TICKS-1. At the last count the step advances; after step 3 completes the block goes to GAP.
REQ-020 A request arriving during SFX SHALL NOT preempt the current effect; it remains pending.
REQ-021 GAP SHALL last exactly one tick with note=0.
REQ-022 On the tick that ends GAP: if eff != 0, go to SFX; else if bgm_en=1, go to BGM; else go to IDLE.
REQ-023 From IDLE, on tick with eff=0 and bgm_en=1: go to BGM.
REQ-024 From BGM, on tick with eff=0 and bgm_en=0: go to IDLE with note=0.
REQ-025 In BGM, on tick with eff=0 and bgm_en=1: note <= bgm_note and bgm_adv=1 for that cycle only.
REQ-026 bgm_adv SHALL be 0 in every other case, including the tick on which BGM is left for SFX. The score is therefore paused, not skipped.
REQ-027 In IDLE, note SHALL be 0.
REQ-028 sfx_busy SHALL be 1 exactly when the state is SFX or GAP.
REQ-029 bgm_note values greater than 21 SHALL be passed through unchanged; range checking is not done in this block.
REQ-030 All outputs SHALL be registered.
REQ-031 Non-tick cycles SHALL hold state, note, counters and step index.

Reset
REQ-032 On rst=0 (asynchronous), the block SHALL force: state=IDLE, note=0, bgm_adv=0, sfx_busy=0, pend=0, step index=0, hold counter=0.
REQ-033 Reset asserted mid-effect SHALL abort the effect and discard all pending requests.
REQ-034 After reset release, the first action SHALL occur on the next tick.

Verification
REQ-035 Music path: rst release, bgm_en=1, bgm_note=10, tick every 8 cycles -> first tick: state BGM, no adv. Each following tick: note=10 and a 1-cycle bgm_adv.
REQ-036 Win effect: in BGM, pulse sfx_req=3'b100 between ticks -> next tick: state SFX, note=8, no adv. note sequence 8,8,10,10,12,12,15,15 over ticks, then one tick note=0 (GAP), then BGM with bgm_adv resuming.
REQ-037 Priority and pending: sfx_req=3'b011 pulsed in the same cycle as tick -> lose plays now (note=12 first). tie stays pending and plays directly after the GAP with no BGM tick in between.
REQ-038 No preemption: during lose step 1, pulse win -> lose completes all 4 steps. GAP follows, then win plays.
REQ-039 Disable: bgm_en=0 during an effect -> after GAP, state IDLE, note=0, no bgm_adv.
REQ-040 Reset mid-effect: assert rst during SFX step 2 with tie pending -> outputs clear immediately. After release plus one tick with bgm_en=1, state is BGM and no effect plays.
